// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM access controller: FSM state encoding,
// default widths and the legal WAIT_CYCLES range.
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF      = 11;
  localparam int DATA_W_DEF      = 8;
  localparam int LEN_W_DEF       = 4;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int WAIT_CYCLES_MIN = 1;
  localparam int WAIT_CYCLES_MAX = 15;
  localparam int WAIT_CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  function automatic logic wait_cycles_legal(input int w);
    return (w >= WAIT_CYCLES_MIN) && (w <= WAIT_CYCLES_MAX);
  endfunction

endpackage

// File: rtl/sram_beat_counter.sv
// Wait-cycle and remaining-beat down-counters with load, decrement and zero flags.
// Single-cycle update; load wins over decrement, decrement saturates at zero.
module sram_beat_counter
  import sram_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wait_load_i,
  input  logic [WAIT_CNT_W-1:0] wait_init_i,
  input  logic                  wait_dec_i,
  output logic                  wait_zero_o,
  input  logic                  beat_load_i,
  input  logic [LEN_W-1:0]      beat_init_i,
  input  logic                  beat_dec_i,
  output logic                  beat_zero_o
);

  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic [LEN_W-1:0]      beat_q, beat_d;

  always_comb begin
    wait_d = wait_q;
    if (wait_load_i) begin
      wait_d = wait_init_i;
    end else if (wait_dec_i && (wait_q != '0)) begin
      wait_d = wait_q - WAIT_CNT_W'(1);
    end
  end

  always_comb begin
    beat_d = beat_q;
    if (beat_load_i) begin
      beat_d = beat_init_i;
    end else if (beat_dec_i && (beat_q != '0)) begin
      beat_d = beat_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= '0;
      beat_q <= '0;
    end else begin
      wait_q <= wait_d;
      beat_q <= beat_d;
    end
  end

  assign wait_zero_o = (wait_q == '0);
  assign beat_zero_o = (beat_q == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Async SRAM controller: each beat is SETUP, WAIT_CYCLES x ACCESS, HOLD; requests held off by req_ready=0 outside IDLE.
// Read bursts of req_len+1 beats only when SRAM_ACCESS_CTRL_BURST_EN is defined; otherwise every read is one beat.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int LEN_W       = LEN_W_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_rnw,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  input  logic [DATA_W-1:0] sram_din
);

  if (!wait_cycles_legal(WAIT_CYCLES)) begin : g_bad_wait_cycles
    $error("sram_access_ctrl: WAIT_CYCLES out of range");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              accept;
  logic              wait_zero, beat_zero;
  logic [LEN_W-1:0]  beat_init;

  assign accept = (state_q == ST_IDLE) && req_valid;

`ifdef SRAM_ACCESS_CTRL_BURST_EN
  assign beat_init = req_write ? '0 : req_len;
`else
  logic unused_req_len;
  assign unused_req_len = ^req_len;
  assign beat_init      = '0;
`endif

  sram_beat_counter #(
    .LEN_W (LEN_W)
  ) u_beat_counter (
    .clk_i       (clk_clk),
    .rst_i       (reset_reset),
    .wait_load_i (state_q == ST_SETUP),
    .wait_init_i (WAIT_CNT_W'(WAIT_CYCLES - 1)),
    .wait_dec_i  (state_q == ST_ACCESS),
    .wait_zero_o (wait_zero),
    .beat_load_i (accept),
    .beat_init_i (beat_init),
    .beat_dec_i  (state_q == ST_HOLD),
    .beat_zero_o (beat_zero)
  );

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (wait_zero) state_d = ST_HOLD;
      ST_HOLD:   state_d = beat_zero ? ST_IDLE : ST_SETUP;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    busy         = 1'b1;
    sram_cs_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_rnw     = 1'b1;
    sram_dout_en = 1'b0;
    rsp_valid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_SETUP: begin
        sram_cs_n    = 1'b0;
        sram_rnw     = ~write_q;
        sram_dout_en = write_q;
      end
      ST_ACCESS: begin
        sram_cs_n    = 1'b0;
        sram_oe_n    = write_q;
        sram_rnw     = ~write_q;
        sram_dout_en = write_q;
      end
      ST_HOLD: begin
        sram_dout_en = write_q;
        rsp_valid    = ~write_q;
      end
      default: ;
    endcase
  end

  assign rsp_last     = rsp_valid && beat_zero;
  assign rsp_rdata    = rdata_q;
  assign sram_address = addr_q;
  assign sram_dout    = wdata_q;

  // Read data is captured on the final ACCESS clock so it is stable for the whole HOLD strobe.
  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept) begin
      addr_d  = req_addr;
      write_d = req_write;
      wdata_d = req_wdata;
    end
    if ((state_q == ST_HOLD) && !beat_zero) begin
      addr_d = addr_q + ADDR_W'(1);
    end
    if ((state_q == ST_ACCESS) && wait_zero && !write_q) begin
      rdata_d = sram_din;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with WAIT_CYCLES=2; SRAM model returns addr[7:0]^0xF0 while oe_n is low.
module tb_sram_access_ctrl;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int WC = 2;

  logic          clk_clk     = 1'b0;
  logic          reset_reset = 1'b0;
  logic          req_valid   = 1'b0;
  logic          req_write   = 1'b0;
  logic [AW-1:0] req_addr    = '0;
  logic [DW-1:0] req_wdata   = '0;
  logic [LW-1:0] req_len     = '0;
  logic          req_ready, rsp_valid, rsp_last, busy;
  logic [DW-1:0] rsp_rdata, sram_dout, sram_din;
  logic [AW-1:0] sram_address;
  logic          sram_cs_n, sram_oe_n, sram_rnw, sram_dout_en;

  int checks   = 0;
  int failures = 0;

  sram_access_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .LEN_W(LW)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .busy(busy),
    .sram_address(sram_address), .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n),
    .sram_rnw(sram_rnw), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
    .sram_din(sram_din)
  );

  always #5 clk_clk = ~clk_clk;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hF0;
  endfunction

  assign sram_din = !sram_oe_n ? mem_f(sram_address) : 8'h00;

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  // Drive a request so it is accepted at the next edge; returns in cycle 1 (SETUP).
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LW-1:0] l);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_len = l;
    tick();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;
  endtask

  task automatic test_reset();
    #2 reset_reset = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, req_ready, sram_cs_n, sram_oe_n, sram_rnw, sram_dout_en, rsp_valid, rsp_last} !== 8'b0111_1000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", {busy, req_ready, sram_cs_n, sram_oe_n, sram_rnw, sram_dout_en, rsp_valid, rsp_last}, 8'b0111_1000);
    end
    checks++;
    if ({sram_address, sram_dout, rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", sram_address, sram_dout, rsp_rdata);
    end
    reset_reset = 1'b0;
    tick();
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release got=%b exp=10", {req_ready, busy});
    end
  endtask

  task automatic test_write();
    int cs_cnt = 0, rsp_cnt = 0, hold_bad = 0;
    logic [2:0] rnw_v;
    logic [3:0] tail;
    issue(1'b1, 11'h155, 8'hA5, 4'hF);
    for (int c = 1; c <= 5; c++) begin
      if (!sram_cs_n) cs_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (c <= 4 && (sram_dout !== 8'hA5 || sram_dout_en !== 1'b1 || sram_address !== 11'h155)) hold_bad++;
      if (c >= 2 && c <= 4) rnw_v[c-2] = sram_rnw;
      if (c == 5) tail = {req_ready, busy, sram_dout_en, sram_rnw};
      else tick();
    end
    checks++;
    if (cs_cnt !== 1 + WC) begin failures++; $display("FAIL write_cs_len got=%0d exp=%0d", cs_cnt, 1 + WC); end
    checks++;
    if (rsp_cnt !== 0) begin failures++; $display("FAIL write_no_rsp got=%0d exp=0", rsp_cnt); end
    checks++;
    if (hold_bad !== 0) begin failures++; $display("FAIL write_dout_stable bad_cycles=%0d exp=0", hold_bad); end
    checks++;
    if (rnw_v !== 3'b100) begin failures++; $display("FAIL write_rnw got=%b exp=100", rnw_v); end
    checks++;
    if (tail !== 4'b1001) begin failures++; $display("FAIL write_idle got=%b exp=1001", tail); end
  endtask

  task automatic test_read();
    int rsp_cnt = 0, rsp_cyc = 0, en_cnt = 0;
    logic [DW-1:0] rd = '0;
    logic rl = 1'b0, ready5 = 1'b0;
    logic [4:0] oe_v, cs_v;
    issue(1'b0, 11'h155, 8'h00, 4'h0);
    for (int c = 1; c <= 5; c++) begin
      oe_v[c-1] = sram_oe_n;
      cs_v[c-1] = sram_cs_n;
      if (sram_dout_en) en_cnt++;
      if (rsp_valid) begin rsp_cnt++; rsp_cyc = c; rd = rsp_rdata; rl = rsp_last; end
      if (c == 5) ready5 = req_ready;
      else tick();
    end
    checks++;
    if (rsp_cnt !== 1 || rsp_cyc !== 4) begin failures++; $display("FAIL read_rsp_timing got=%0d@%0d exp=1@4", rsp_cnt, rsp_cyc); end
    checks++;
    if (rd !== 8'hA5 || rl !== 1'b1) begin failures++; $display("FAIL read_data got=%h last=%b exp=a5 last=1", rd, rl); end
    checks++;
    if (oe_v !== 5'b11001 || cs_v !== 5'b11000) begin failures++; $display("FAIL read_strobes oe=%b cs=%b exp oe=11001 cs=11000", oe_v, cs_v); end
    checks++;
    if (ready5 !== 1'b1 || en_cnt !== 0) begin failures++; $display("FAIL read_ready_en ready=%b en=%0d exp ready=1 en=0", ready5, en_cnt); end
  endtask

`ifdef SRAM_ACCESS_CTRL_BURST_EN
  task automatic test_burst();
    logic [AW-1:0] exp_a [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    logic [DW-1:0] exp_d [4] = '{8'h0E, 8'h0F, 8'hF0, 8'hF1};
    int idx = 0, rsp_bad = 0, addr_bad = 0;
    logic [1:0] tail = '0;
    issue(1'b0, 11'h7FE, 8'h00, 4'd3);
    for (int c = 1; c <= 17; c++) begin
      if (c % 4 == 1 && c < 17 && sram_address !== exp_a[(c-1)/4]) addr_bad++;
      if (rsp_valid) begin
        if (idx > 3 || c !== 4 * (idx + 1) || rsp_rdata !== exp_d[idx & 3] || rsp_last !== (idx == 3)) rsp_bad++;
        idx++;
      end
      if (c == 17) tail = {req_ready, busy};
      else tick();
    end
    checks++;
    if (idx !== 4) begin failures++; $display("FAIL burst_count got=%0d exp=4", idx); end
    checks++;
    if (rsp_bad !== 0) begin failures++; $display("FAIL burst_beats bad=%0d exp=0", rsp_bad); end
    checks++;
    if (addr_bad !== 0) begin failures++; $display("FAIL burst_addr_wrap bad=%0d exp=0", addr_bad); end
    checks++;
    if (tail !== 2'b10) begin failures++; $display("FAIL burst_idle got=%b exp=10", tail); end
  endtask
`else
  task automatic test_no_burst();
    int rsp_cnt = 0, rsp_cyc = 0, cs_cnt = 0;
    logic [DW-1:0] rd = '0;
    logic rl = 1'b0;
    issue(1'b0, 11'h0AA, 8'h00, 4'd5);
    for (int c = 1; c <= 12; c++) begin
      if (!sram_cs_n) cs_cnt++;
      if (rsp_valid) begin rsp_cnt++; rsp_cyc = c; rd = rsp_rdata; rl = rsp_last; end
      if (c < 12) tick();
    end
    checks++;
    if (rsp_cnt !== 1 || rsp_cyc !== 4) begin failures++; $display("FAIL noburst_rsp got=%0d@%0d exp=1@4", rsp_cnt, rsp_cyc); end
    checks++;
    if (rd !== 8'h5A || rl !== 1'b1) begin failures++; $display("FAIL noburst_data got=%h last=%b exp=5a last=1", rd, rl); end
    checks++;
    if (cs_cnt !== 3) begin failures++; $display("FAIL noburst_single_beat cs_cycles=%0d exp=3", cs_cnt); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [9:0] ready_v;
    int rsp_cnt = 0, rsp_bad = 0, addr_bad = 0;
    logic gap_cs = 1'b0, gap_busy = 1'b1;
    logic [AW-1:0] a6 = '0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 11'h120; req_len = '0;
    tick();
    req_addr = 11'h121;
    for (int c = 1; c <= 10; c++) begin
      ready_v[c-1] = req_ready;
      if (c <= 4 && sram_address !== 11'h120) addr_bad++;
      if (c == 5) begin gap_cs = sram_cs_n; gap_busy = busy; end
      if (c == 6) begin a6 = sram_address; req_valid = 1'b0; req_addr = '0; end
      if (rsp_valid) begin
        rsp_cnt++;
        if (!((c == 4 && rsp_rdata === 8'hD0) || (c == 9 && rsp_rdata === 8'hD1))) rsp_bad++;
      end
      if (c < 10) tick();
    end
    checks++;
    if (ready_v !== 10'h210) begin failures++; $display("FAIL b2b_ready got=%b exp=%b", ready_v, 10'h210); end
    checks++;
    if (gap_cs !== 1'b1 || gap_busy !== 1'b0) begin failures++; $display("FAIL b2b_gap cs_n=%b busy=%b exp cs_n=1 busy=0", gap_cs, gap_busy); end
    checks++;
    if (a6 !== 11'h121 || addr_bad !== 0) begin failures++; $display("FAIL b2b_addr got=%h bad=%0d exp=121 bad=0", a6, addr_bad); end
    checks++;
    if (rsp_cnt !== 2 || rsp_bad !== 0) begin failures++; $display("FAIL b2b_rsp cnt=%0d bad=%0d exp cnt=2 bad=0", rsp_cnt, rsp_bad); end
  endtask

  task automatic test_reset_mid();
`ifdef SRAM_ACCESS_CTRL_BURST_EN
    localparam int RST_CYC = 7;
    localparam logic [LW-1:0] LEN = 4'd3;
`else
    localparam int RST_CYC = 3;
    localparam logic [LW-1:0] LEN = 4'd0;
`endif
    int rsp_cnt = 0, nrdy = 0;
    issue(1'b0, 11'h010, 8'h00, LEN);
    for (int c = 1; c < RST_CYC; c++) tick();
    checks++;
    if (sram_oe_n !== 1'b0 || sram_cs_n !== 1'b0) begin failures++; $display("FAIL rstmid_pre oe_n=%b cs_n=%b exp 0/0", sram_oe_n, sram_cs_n); end
    reset_reset = 1'b1;
    #1;
    checks++;
    if ({busy, req_ready, sram_cs_n, sram_oe_n, sram_rnw, sram_dout_en, rsp_valid, rsp_last} !== 8'b0111_1000 ||
        {sram_address, sram_dout, rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL rstmid_idle ctrl=%b addr=%h dout=%h rdata=%h exp ctrl=01111000 others 0",
               {busy, req_ready, sram_cs_n, sram_oe_n, sram_rnw, sram_dout_en, rsp_valid, rsp_last}, sram_address, sram_dout, rsp_rdata);
    end
    tick(); tick();
    reset_reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rsp_valid) rsp_cnt++;
      if (!req_ready) nrdy++;
    end
    checks++;
    if (rsp_cnt !== 0 || nrdy !== 0) begin failures++; $display("FAIL rstmid_after rsp=%0d not_ready=%0d exp 0/0", rsp_cnt, nrdy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
`ifdef SRAM_ACCESS_CTRL_BURST_EN
    test_burst();
`else
    test_no_burst();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
